// File: rtl/nibble_add_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
package nibble_add_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ADD  = ST_ADD,
        S_DONE = ST_DONE
    } state_t;

    // Nibble index width: clog2(nibbles), never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        int w;
        w = 1;
        while ((1 << w) < nibbles) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder slice with carry in and carry out.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign s     = total[3:0];
    assign cout  = total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit slice, LSB nibble first, one nibble per clock.
//
//   state  | meaning
//   IDLE   | waiting for start; operands captured on accept
//   ADD    | one nibble summed per edge; result published on the last nibble
//   DONE   | one-cycle done pulse, then back to IDLE
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W = NIBBLES * NIB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Sum,
    output logic         Carry_out
);

    localparam int IW = idx_width(NIBBLES);
    localparam int SW = IW + 2;

    generate
        if (NIBBLES < 1 || NIBBLES > 16) begin : g_bad_nibbles
            $error("nibble_serial_adder: NIBBLES must be within 1..16");
        end
    endgenerate

    state_t state;
    state_t state_next;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  work_sum;
    logic          carry_reg;
    logic [IW-1:0] idx;

    logic [SW-1:0] shamt;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s_nib;
    logic          nib_cout;
    logic [W-1:0]  nib_mask;
    logic [W-1:0]  nib_ins;
    logic [W-1:0]  work_sum_next;
    logic          last_nib;

    // Nibble select and insert by shifting, so no part-select ever leaves the operand range.
    assign shamt         = {idx, 2'b00};
    assign a_nib         = NIB_W'(a_reg >> shamt);
    assign b_nib         = NIB_W'(b_reg >> shamt);
    assign nib_mask      = W'(4'hF) << shamt;
    assign nib_ins       = W'(s_nib) << shamt;
    assign work_sum_next = (work_sum & ~nib_mask) | nib_ins;
    assign last_nib      = (idx == IW'(NIBBLES - 1));

    nibble_add4 u_add4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg),
        .s    (s_nib),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (last_nib) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work_sum  <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            Sum       <= '0;
            Carry_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        carry_reg <= Carry_in;
                        idx       <= '0;
                        work_sum  <= '0;
                    end
                end
                S_ADD: begin
                    work_sum  <= work_sum_next;
                    carry_reg <= nib_cout;
                    idx       <= idx + 1'b1;
                    // Outputs move only here, so partial sums are never visible.
                    if (last_nib) begin
                        Sum       <= work_sum_next;
                        Carry_out <= nib_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: 4-nibble instance plus a 1-nibble instance.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Carry_in;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic        Carry_out;

    logic        start1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        cin1;
    logic        busy1;
    logic        done1;
    logic [3:0]  sum1;
    logic        cout1;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    logic [16:0] exp_q[$];
    logic [16:0] sb_exp;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .Carry_in  (Carry_in),
        .busy      (busy),
        .done      (done),
        .Sum       (Sum),
        .Carry_out (Carry_out)
    );

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .A         (a1),
        .B         (b1),
        .Carry_in  (cin1),
        .busy      (busy1),
        .done      (done1),
        .Sum       (sum1),
        .Carry_out (cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pops one expected result.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(exp_q.size()), 1);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sum", {16'h0, Sum}, {16'h0, sb_exp[15:0]});
                check("carry_out", {31'h0, Carry_out}, {31'h0, sb_exp[16]});
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        start    = 1'b1;
        A        = a;
        B        = b;
        Carry_in = c;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {16'h0, c});
        @(negedge clk);
        start    = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        Carry_in = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (done) return;
        end
        check("done_timeout", {31'h0, done}, 1);
    endtask

    initial begin
        int cnt;
        int b0;
        int d0;

        start = 1'b0; A = '0; B = '0; Carry_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_sum", {16'h0, Sum}, 0);
        check("rst_cout", {31'h0, Carry_out}, 0);
        check("rst_sum1", {28'h0, sum1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic add, latency and busy length
        b0 = busy_cnt;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(cnt);
        check("lat_basic", 32'(cnt), 4);
        @(negedge clk);
        check("busy_cycles", 32'(busy_cnt - b0), 5);
        check("idle_after_done", {31'h0, busy}, 0);

        // starts during ADD and DONE are ignored; Sum holds until DONE
        d0 = done_cnt;
        start_op(16'h0001, 16'h0001, 1'b0);
        start = 1'b1; A = 16'hAAAA; B = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        check("sum_hold", {16'h0, Sum}, 32'h5555);
        wait_done(cnt);
        check("lat_ignore", 32'(cnt), 3);
        start = 1'b1; A = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", {31'h0, busy}, 0);
        repeat (3) @(negedge clk);
        check("still_idle", {31'h0, busy}, 0);
        check("one_done_pulse", 32'(done_cnt - d0), 1);

        // carry across nibble boundary
        start_op(16'h00FF, 16'h0001, 1'b0);
        wait_done(cnt);
        check("lat_ripple", 32'(cnt), 4);
        @(negedge clk);

        // reset mid-operation
        start_op(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_busy", {31'h0, busy}, 0);
        check("abort_done", {31'h0, done}, 0);
        check("abort_sum", {16'h0, Sum}, 0);
        check("abort_cout", {31'h0, Carry_out}, 0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt - d0), 0);
        start_op(16'h0003, 16'h0004, 1'b0);
        wait_done(cnt);
        check("lat_after_reset", 32'(cnt), 4);
        @(negedge clk);

        // all-ones with carry in, then back-to-back start in the IDLE cycle after DONE
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(cnt);
        @(negedge clk);
        start_op(16'hFFFF, 16'h0000, 1'b1);
        wait_done(cnt);
        check("lat_back_to_back", 32'(cnt), 4);
        @(negedge clk);

        // single-nibble instance
        start1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
        check("n1_busy", {31'h0, busy1}, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt++;
            if (done1) break;
        end
        check("n1_lat", 32'(cnt), 1);
        check("n1_sum", {28'h0, sum1}, 0);
        check("n1_cout", {31'h0, cout1}, 1);
        @(negedge clk);
        start1 = 1'b1; a1 = 4'h5; b1 = 4'h9; cin1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("n1_done2", {31'h0, done1}, 1);
        check("n1_sum2", {28'h0, sum1}, 32'hF);
        check("n1_cout2", {31'h0, cout1}, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
